// File: rtl/atm_pkg.sv
// Shared definitions for the parametrised ATM controller: state encoding,
// BCD digit width and the default PIN / opening balance.
package atm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PIN_ENTRY = 3'd1,
      ST_DEPOSIT   = 3'd2,
      ST_WITHDRAW  = 3'd3,
      ST_LOCKED    = 3'd4
   } atm_state_t;

   localparam int          BCD_W            = 4;
   localparam logic [31:0] DEF_PIN_CODE     = 32'h0000_4756;
   localparam int          DEF_INIT_BALANCE = 4500;

endpackage

// File: rtl/atm_pin_buffer.sv
// PIN entry buffer: shifts BCD digits in (first digit ends up most
// significant), counts them, and flags full / matches-the-stored-PIN.
module atm_pin_buffer
   import atm_pkg::*;
#(
   parameter int          PIN_DIGITS = 4,
   parameter logic [31:0] PIN_CODE   = DEF_PIN_CODE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic [BCD_W-1:0] digit,
   output logic             full,
   output logic             match
);

   localparam int BUF_W = BCD_W * PIN_DIGITS;
   localparam int CNT_W = $clog2(PIN_DIGITS + 1);

   logic [BUF_W-1:0] pin_q;
   logic [CNT_W-1:0] cnt_q;

   assign full  = (cnt_q == CNT_W'(PIN_DIGITS));
   assign match = full && (pin_q == PIN_CODE[BUF_W-1:0]);

   // Shift in a digit while not yet full; extra digits are dropped.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pin_q <= '0;
         cnt_q <= '0;
      end else if (shift_en && !full) begin
         pin_q <= (pin_q << BCD_W) | BUF_W'(digit);
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/atm_ctrl_param.sv
// Parametrised single-account ATM controller: card, N-digit PIN with
// attempt limiting, then one deposit (saturating) or withdrawal (funds
// checked). All outputs are registered.
// Optional build macro ATM_TIMEOUT_EN adds an idle timeout back to IDLE.
module atm_ctrl_param
   import atm_pkg::*;
#(
   parameter int                PIN_DIGITS   = 4,
   parameter logic [31:0]       PIN_CODE     = DEF_PIN_CODE,
   parameter int                MAX_TRIES    = 3,
   parameter int                AMT_W        = 32,
   parameter int                BAL_W        = 64,
   parameter logic [BAL_W-1:0]  INIT_BALANCE = BAL_W'(DEF_INIT_BALANCE),
   parameter int                TIMEOUT_CYC  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             card_in,
   input  logic             trans_type,
   input  logic             digit_stb,
   input  logic [3:0]       digit,
   input  logic             enter_stb,
   input  logic             amount_stb,
   input  logic [AMT_W-1:0] amount,
   output logic [BAL_W-1:0] balance,
   output logic             balance_updated,
   output logic             dispense,
   output logic             pin_wrong,
   output logic             warning,
   output logic             locked,
   output logic             insufficient,
   output logic             busy
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   atm_state_t       state_q, state_d;
   logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
   logic [BAL_W-1:0] bal_d, amt_ext;
   logic             warn_d, lock_d, upd_d, disp_d, wrong_d, insuf_d;
   logic             buf_clr, buf_shift, pin_full, pin_match;
   logic             tmo_hit;

   // Saturating add of a zero-extended amount onto the balance.
   function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                input logic [BAL_W-1:0] b);
      logic [BAL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
   endfunction

   assign amt_ext   = BAL_W'(amount);
   assign tries_inc = tries_q + TRY_W'(1);

   atm_pin_buffer #(
      .PIN_DIGITS (PIN_DIGITS),
      .PIN_CODE   (PIN_CODE)
   ) u_pin_buffer (
      .clk      (clk),
      .rst      (rst),
      .clr      (buf_clr),
      .shift_en (buf_shift),
      .digit    (digit),
      .full     (pin_full),
      .match    (pin_match)
   );

`ifdef ATM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_active, any_stb;

   assign tmo_active = (state_q == ST_PIN_ENTRY) || (state_q == ST_DEPOSIT) ||
                       (state_q == ST_WITHDRAW);
   assign any_stb    = digit_stb || enter_stb || amount_stb;
   assign tmo_hit    = tmo_active && !any_stb && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   // Idle-cycle counter: runs in active states, any strobe restarts it.
   always_ff @(posedge clk) begin
      if (rst || !tmo_active || any_stb || tmo_hit)
         tmo_q <= '0;
      else
         tmo_q <= tmo_q + TMO_W'(1);
   end
`else
   wire unused_timeout_cyc = ^TIMEOUT_CYC;
   assign tmo_hit = 1'b0;
`endif

   // Next-state, next-balance and next-output decode.
   always_comb begin
      state_d   = state_q;
      tries_d   = tries_q;
      bal_d     = balance;
      warn_d    = warning;
      lock_d    = locked;
      upd_d     = 1'b0;
      disp_d    = 1'b0;
      wrong_d   = 1'b0;
      insuf_d   = 1'b0;
      buf_clr   = 1'b0;
      buf_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (card_in) begin
               state_d = ST_PIN_ENTRY;
               buf_clr = 1'b1;
            end
         end
         ST_PIN_ENTRY: begin
            if (enter_stb) begin
               buf_clr = 1'b1;
               if (pin_match) begin
                  tries_d = '0;
                  warn_d  = 1'b0;
                  state_d = trans_type ? ST_WITHDRAW : ST_DEPOSIT;
               end else begin
                  wrong_d = 1'b1;
                  tries_d = tries_inc;
                  if (tries_inc == TRY_W'(MAX_TRIES)) begin
                     state_d = ST_LOCKED;
                     lock_d  = 1'b1;
                     warn_d  = 1'b0;
                  end else if (tries_inc == TRY_W'(MAX_TRIES - 1)) begin
                     warn_d = 1'b1;
                  end
               end
            end else if (digit_stb) begin
               buf_shift = 1'b1;
            end
         end
         ST_DEPOSIT: begin
            if (amount_stb) begin
               bal_d   = sat_add(balance, amt_ext);
               upd_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WITHDRAW: begin
            if (amount_stb) begin
               state_d = ST_IDLE;
               if (amt_ext > balance) begin
                  insuf_d = 1'b1;
               end else begin
                  bal_d  = balance - amt_ext;
                  disp_d = 1'b1;
                  upd_d  = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
         end
         default: state_d = ST_IDLE;
      endcase
      if (tmo_hit) begin
         state_d = ST_IDLE;
         buf_clr = 1'b1;
      end
   end

   // State, balance and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         tries_q         <= '0;
         balance         <= INIT_BALANCE;
         warning         <= 1'b0;
         locked          <= 1'b0;
         balance_updated <= 1'b0;
         dispense        <= 1'b0;
         pin_wrong       <= 1'b0;
         insufficient    <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state_q         <= state_d;
         tries_q         <= tries_d;
         balance         <= bal_d;
         warning         <= warn_d;
         locked          <= lock_d;
         balance_updated <= upd_d;
         dispense        <= disp_d;
         pin_wrong       <= wrong_d;
         insufficient    <= insuf_d;
         busy            <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Directed self-checking bench for atm_ctrl_param.
module tb_atm_ctrl_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        card_in = 1'b0, trans_type = 1'b0, digit_stb = 1'b0;
   logic [3:0]  digit = 4'd0;
   logic        enter_stb = 1'b0, amount_stb = 1'b0;
   logic [31:0] amount = 32'd0;

   logic [63:0] balance;
   logic        balance_updated, dispense, pin_wrong, warning, locked, insufficient, busy;

   logic [15:0] s_balance;
   logic        s_updated, s_dispense, s_pin_wrong, s_warning, s_locked, s_insuf, s_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   atm_ctrl_param #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .card_in(card_in), .trans_type(trans_type),
      .digit_stb(digit_stb), .digit(digit), .enter_stb(enter_stb),
      .amount_stb(amount_stb), .amount(amount), .balance(balance),
      .balance_updated(balance_updated), .dispense(dispense), .pin_wrong(pin_wrong),
      .warning(warning), .locked(locked), .insufficient(insufficient), .busy(busy)
   );

   atm_ctrl_param #(.AMT_W(16), .BAL_W(16), .INIT_BALANCE(16'hFFC0), .TIMEOUT_CYC(16)) dut_s (
      .clk(clk), .rst(rst), .card_in(card_in), .trans_type(trans_type),
      .digit_stb(digit_stb), .digit(digit), .enter_stb(enter_stb),
      .amount_stb(amount_stb), .amount(amount[15:0]), .balance(s_balance),
      .balance_updated(s_updated), .dispense(s_dispense), .pin_wrong(s_pin_wrong),
      .warning(s_warning), .locked(s_locked), .insufficient(s_insuf), .busy(s_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic card();
      card_in = 1'b1;
      tick();
      card_in = 1'b0;
   endtask

   task automatic key(input logic [3:0] d);
      digit = d;
      digit_stb = 1'b1;
      tick();
      digit_stb = 1'b0;
   endtask

   task automatic submit(input logic tt);
      trans_type = tt;
      enter_stb = 1'b1;
      tick();
      enter_stb = 1'b0;
   endtask

   task automatic good_pin();
      key(4'd4); key(4'd7); key(4'd5); key(4'd6);
   endtask

   task automatic bad_pin();
      key(4'd1); key(4'd2); key(4'd3); key(4'd4);
   endtask

   task automatic txn(input logic [31:0] amt);
      amount = amt;
      amount_stb = 1'b1;
      tick();
      amount_stb = 1'b0;
   endtask

   initial begin
      tick();
      do_rst();
      chk("rst_balance", balance, 64'd4500);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_locked", {63'd0, locked}, 64'd0);
      chk("rst_warning", {63'd0, warning}, 64'd0);
      chk("rst_pulses", {60'd0, balance_updated, dispense, pin_wrong, insufficient}, 64'd0);
      chk("rst_s_balance", {48'd0, s_balance}, 64'h0000_0000_0000_FFC0);

      // Deposit 100 after a correct PIN; the narrow instance saturates.
      card();
      chk("card_busy", {63'd0, busy}, 64'd1);
      good_pin();
      submit(1'b0);
      chk("dep_pin_ok", {63'd0, pin_wrong}, 64'd0);
      chk("dep_busy", {63'd0, busy}, 64'd1);
      txn(32'd100);
      chk("dep_balance", balance, 64'd4600);
      chk("dep_updated", {63'd0, balance_updated}, 64'd1);
      chk("dep_dispense", {63'd0, dispense}, 64'd0);
      chk("dep_idle", {63'd0, busy}, 64'd0);
      chk("sat_balance", {48'd0, s_balance}, 64'h0000_0000_0000_FFFF);
      tick();
      chk("dep_pulse_1cyc", {63'd0, balance_updated}, 64'd0);

      // Withdraw more than balance, then exactly the balance.
      do_rst();
      card(); good_pin(); submit(1'b1);
      txn(32'd5000);
      chk("wd_insuf", {63'd0, insufficient}, 64'd1);
      chk("wd_insuf_bal", balance, 64'd4500);
      chk("wd_insuf_nodisp", {62'd0, dispense, balance_updated}, 64'd0);
      chk("wd_insuf_idle", {63'd0, busy}, 64'd0);
      card(); good_pin(); submit(1'b1);
      txn(32'd4500);
      chk("wd_exact_pulses", {61'd0, dispense, balance_updated, insufficient}, 64'd6);
      chk("wd_exact_bal", balance, 64'd0);

      // Fifth digit dropped; digit coincident with enter dropped.
      do_rst();
      card(); good_pin(); key(4'd9); submit(1'b0);
      chk("extra_digit_ok", {63'd0, pin_wrong}, 64'd0);
      txn(32'd10);
      chk("extra_digit_bal", balance, 64'd4510);
      card(); key(4'd4); key(4'd7); key(4'd5);
      digit = 4'd6; digit_stb = 1'b1; trans_type = 1'b0; enter_stb = 1'b1;
      tick();
      digit_stb = 1'b0; enter_stb = 1'b0;
      chk("same_cycle_wrong", {63'd0, pin_wrong}, 64'd1);
      chk("same_cycle_busy", {63'd0, busy}, 64'd1);
      good_pin(); submit(1'b1);
      chk("retry_ok", {62'd0, pin_wrong, warning}, 64'd0);
      txn(32'd10);
      chk("retry_wd_bal", balance, 64'd4500);
      chk("retry_wd_disp", {63'd0, dispense}, 64'd1);

      // Three wrong PINs lock the account.
      do_rst();
      card(); bad_pin(); submit(1'b0);
      chk("wrong1", {61'd0, pin_wrong, warning, locked}, 64'd4);
      bad_pin(); submit(1'b0);
      chk("wrong2", {61'd0, pin_wrong, warning, locked}, 64'd6);
      tick();
      chk("wrong2_pulse_end", {61'd0, pin_wrong, warning, locked}, 64'd2);
      bad_pin(); submit(1'b0);
      chk("wrong3", {61'd0, pin_wrong, warning, locked}, 64'd5);
      card(); good_pin(); submit(1'b0); txn(32'd100);
      chk("locked_ignore", {61'd0, pin_wrong, locked, balance_updated}, 64'd2);
      chk("locked_bal", balance, 64'd4500);
      chk("locked_busy", {63'd0, busy}, 64'd1);
      do_rst();
      chk("unlock_rst", {62'd0, locked, busy}, 64'd0);

      // Reset during WITHDRAW aborts; amount in IDLE is ignored.
      card(); good_pin(); submit(1'b1);
      chk("wd_wait_busy", {63'd0, busy}, 64'd1);
      do_rst();
      chk("abort_idle", {63'd0, busy}, 64'd0);
      chk("abort_pulses", {60'd0, balance_updated, dispense, pin_wrong, insufficient}, 64'd0);
      chk("abort_bal", balance, 64'd4500);
      txn(32'd100);
      chk("idle_amount_ign", {63'd0, balance_updated}, 64'd0);
      chk("idle_amount_bal", balance, 64'd4500);

      // Idle behaviour in PIN_ENTRY with one wrong attempt recorded.
      card(); bad_pin(); submit(1'b0);
      chk("tmo_wrong1", {63'd0, pin_wrong}, 64'd1);
      repeat (10) tick();
      chk("tmo_early_busy", {63'd0, busy}, 64'd1);
      repeat (10) tick();
`ifdef ATM_TIMEOUT_EN
      chk("tmo_idle", {63'd0, busy}, 64'd0);
      chk("tmo_nopulse", {62'd0, pin_wrong, warning}, 64'd0);
      card(); bad_pin(); submit(1'b0);
      chk("tmo_tries_kept", {62'd0, warning, locked}, 64'd2);
      bad_pin(); submit(1'b0);
      chk("tmo_lock", {62'd0, warning, locked}, 64'd1);
`else
      chk("no_tmo_busy", {63'd0, busy}, 64'd1);
      bad_pin(); submit(1'b0);
      chk("no_tmo_warn", {62'd0, warning, locked}, 64'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/atm_ctrl_param.md
Name: atm_ctrl_param

Overview:
- Parametrised successor to the team's single-account ATM controller.
- Accepts a card, collects an N-digit BCD PIN, and limits wrong attempts with a warning and a sticky lock.
- Performs a deposit or a withdrawal against an internal balance register. Balance adds saturate; withdrawals are checked for insufficient funds.
- Sits between the keypad/card-reader front end and the cash dispenser; all outputs are registered.

Parameters:
- PIN_DIGITS, 4, number of BCD digits in the PIN (1..8).
- PIN_CODE, 32'h0000_4756, correct PIN; low 4*PIN_DIGITS bits used, first-entered digit most significant.
- MAX_TRIES, 3, wrong attempts before lock (>=2).
- AMT_W, 32, transaction amount width.
- BAL_W, 64, balance width (>= AMT_W).
- INIT_BALANCE, 4500, balance value loaded on reset.
- TIMEOUT_CYC, 1024, idle-cycle limit (used only with ATM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- card_in  in  1  card inserted; sampled only in IDLE.
- trans_type  in  1  0 = deposit, 1 = withdraw; sampled with the PIN-accept enter_stb.
- digit_stb  in  1  one-cycle strobe, digit valid.
- digit  in  4  BCD digit.
- enter_stb  in  1  one-cycle strobe, submit PIN.
- amount_stb  in  1  one-cycle strobe, amount valid.
- amount  in  AMT_W  transaction amount.
- balance  out  BAL_W  current balance.
- balance_updated  out  1  one-cycle pulse.
- dispense  out  1  one-cycle pulse.
- pin_wrong  out  1  one-cycle pulse.
- warning  out  1  level signal: last attempt remaining.
- locked  out  1  level signal: sticky until rst.
- insufficient  out  1  one-cycle pulse.
- busy  out  1  level signal: high when state != IDLE.

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, balance=INIT_BALANCE, tries=0, digit count=0, PIN buffer=0, all pulse/level outputs 0. rst mid-transaction aborts it with no balance change.
- States: IDLE, PIN_ENTRY, DEPOSIT, WITHDRAW, LOCKED.
- Output timing: all outputs change on the clk edge that samples the causing strobe, so they are visible one cycle after the strobe. Pulses last exactly one cycle.
- IDLE: card_in=1 -> PIN_ENTRY, digit count and buffer cleared. tries is retained across cards; only a correct PIN or rst clears it.
- PIN_ENTRY, digit_stb: if count<PIN_DIGITS, buffer={buffer,digit} and count++. If count==PIN_DIGITS, the digit is silently dropped.
- PIN_ENTRY, enter_stb with count==PIN_DIGITS and buffer==PIN_CODE: tries=0, warning=0, then go to WITHDRAW if trans_type=1, else DEPOSIT.
- PIN_ENTRY, enter_stb with any other buffer or count (including incomplete entry): pin_wrong pulse, tries++, buffer and count cleared, stay in PIN_ENTRY.
  - If the new tries==MAX_TRIES-1: warning=1.
  - If the new tries==MAX_TRIES: go to LOCKED, locked=1, warning=0.
- digit_stb and enter_stb in the same cycle: enter_stb is processed and the digit is dropped.
- DEPOSIT, amount_stb: balance=min(balance+amount, 2^BAL_W-1), balance_updated pulse, -> IDLE.
- WITHDRAW, amount_stb with amount>balance: insufficient pulse, balance unchanged, -> IDLE.
- WITHDRAW, amount_stb with amount<=balance: balance-=amount, dispense and balance_updated pulse together, -> IDLE. amount==balance is legal and leaves balance=0.
- amount is zero-extended to BAL_W for compare and arithmetic.
- LOCKED: all strobes ignored; only rst exits.
- Strobes arriving in states that do not consume them are ignored with no side effects.

Optional Feature:
- Macro: ATM_TIMEOUT_EN.
- Defined: a counter increments every cycle in PIN_ENTRY, DEPOSIT or WITHDRAW and clears on any digit_stb, enter_stb or amount_stb. When it reaches TIMEOUT_CYC, the FSM returns to IDLE with buffer and count cleared. tries is retained, warning is kept, and no pulse is emitted.
- Not defined: no counter; the FSM waits in those states indefinitely.

Decomposition:
- Package atm_pkg: state encoding, BCD digit width constant, default PIN/balance constants.
- Sub-module atm_pin_buffer: shift register, digit counter, full flag and compare-equal output. It has its own clear input driven by the FSM.

Test Plan:
- rst; card_in; digits 4,7,5,6; enter_stb with trans_type=0; amount_stb with amount=100 -> balance=4600, balance_updated pulse, busy low the next cycle.
- Correct PIN with trans_type=1, amount=5000 -> insufficient pulse, balance stays 4500. Repeat with amount=4500 -> dispense and balance_updated pulse, balance=0.
- Three wrong PINs (1,2,3,4) -> pin_wrong pulse on each; warning=1 after the 2nd; locked=1 after the 3rd. Further card/digit strobes are ignored until rst.
- Digits 4,7,5,6,9 then enter_stb -> 5th digit dropped, PIN accepted. digit_stb and enter_stb in the same cycle -> digit dropped.
- Deposit with balance near 2^BAL_W-1 (BAL_W overridden to 16): amount=100 -> balance saturates at 16'hFFFF.
- rst asserted while in WITHDRAW before amount_stb -> IDLE, balance=INIT_BALANCE, no pulses. With ATM_TIMEOUT_EN and TIMEOUT_CYC=16: no strobes for 16 cycles in PIN_ENTRY -> IDLE, tries retained.
